gcd_ctrl: RTL and testbench
===========================

# gcd_ctrl

Sequencing controller for the GCD datapath: it runs Euclid's algorithm on two 8-bit operands by issuing repeated divide jobs to the shift-subtract divider and consuming its remainder. It sits directly upstream of the divider. It drives the dividend, divisor and load strobe, waits on the divider's completion flag, and swaps operands until the divisor reaches zero. It then presents the result on a one-cycle done handshake.

## Interface
- WIDTH, 8, operand/result width; the divider is fixed at 8, so no other value is supported
- clk_in  input  1  system clock; all controller state updates on posedge
- rst_n  input  1  reset, asynchronous, active-low
- start  input  1  request; sampled only in IDLE
- A  input  8  first operand, captured on the accepted start edge
- B  input  8  second operand, captured on the accepted start edge
- DIVD_out  output  8  dividend to divider; equals x register
- DIVN_out  output  8  divisor to divider; equals y register, never 0 while load=1
- load  output  1  divider load strobe; high for exactly one cycle per divide
- R  input  8  divider remainder; valid when Div_complete=1 after a load
- Div_complete  input  1  divider done flag (combinational count==0)
- gcd  output  8  result; held from done until the next accepted start
- done  output  1  one-cycle pulse when gcd is valid
- busy  output  1  high in every state except IDLE
- zero_err  output  1  set with done when A=B=0; cleared on next accepted start
- iter  output  4  divide count of last/current job; saturates at 15

## Operation
- Registers: x[7:0], y[7:0], state, iter, gcd, zero_err.
- IDLE: load=0, done=0. When start=1, capture x<=A and y<=B, clear iter and zero_err, then go to CHECK.
- CHECK:
  - y==0: gcd<=x, zero_err<=(x==0), go to DONE.
  - Otherwise go to LOAD.
- LOAD: load=1 for one cycle with DIVD_out=x and DIVN_out=y. The divider captures both on the following negedge. Go to WAIT.
- WAIT: load=0. On a posedge with Div_complete=1, update x<=y, y<=R, iter<=iter+1 (saturating), and go to CHECK.
- DONE: done=1 for one cycle, then IDLE.
- If x<y, the first divide returns R=x, which swaps the operands. No pre-sort is required.
- start while busy: ignored, with no queuing.
- A=0, B≠0 gives one divide of 0/B, R=0, gcd=B.
- A≠0, B=0 gives gcd=A with iter=0.
- A=B=0 gives gcd=0, zero_err=1, iter=0.
- The controller never asserts load with y==0, because the divider priority encoder is undefined for a zero divisor.

## Timing
- Reset (async, rst_n low): state=IDLE; x, y, gcd, iter = 0; done, busy, load, zero_err = 0; DIVD_out and DIVN_out = 0.
- The divider has no reset. Div_complete is ignored outside WAIT. A LOAD always re-initialises the divider count.
- Reset mid-job aborts immediately and no done is issued. The divider may keep running; the next job's LOAD overrides it.
- Let d = 7 − (bit index of MSB of y).
  - The LOAD cycle's negedge sets divider count = d+1.
  - Count decrements on each negedge of the d+1 WAIT cycles.
  - Div_complete is seen high on the posedge ending the (d+1)th WAIT cycle.
  - Div_complete is guaranteed 0 at the first WAIT posedge.
- One iteration = CHECK + LOAD + WAIT = d+3 cycles.
- With the start edge as edge 0, done rises at edge 1 + Σ(d_i+3) and is high for exactly one cycle.
- busy rises at edge 0 and falls with the IDLE return after done.
- x and y, and therefore DIVD_out and DIVN_out, are stable from LOAD entry until the Div_complete update edge.

## Test plan
- Reset: drive rst_n low mid-WAIT of job (48,18) → busy=0, load=0, done=0, gcd=0 immediately. Then start (48,18) → gcd=6, iter=3, zero_err=0.
- A=17, B=0 → done at edge 1, gcd=17, iter=0, load never asserted.
- A=255, B=1 → one divide with d=7; load asserted once; done at edge 11, gcd=1, iter=1.
- A=0, B=0 → gcd=0, zero_err=1, iter=0. A following start (0,5) → gcd=5, iter=1, zero_err=0.
- A=233, B=144 (Fibonacci worst case) → gcd=1, iter=11. Check that each load pulse is one cycle with DIVN_out≠0.
- Pulse start on every cycle during job (48,18) → only the first start is accepted, one done pulse, gcd=6. A new start the cycle after done is accepted.

Source files
------------

// File: rtl/gcd_ctrl.sv
// Euclid GCD sequencer: issues divide jobs to the shift-subtract divider and
// folds each remainder back into the operand pair until the divisor is zero.
module gcd_ctrl (
  input  logic       clk_in,
  input  logic       rst_n,
  input  logic       start,
  input  logic [7:0] A,
  input  logic [7:0] B,
  output logic [7:0] DIVD_out,
  output logic [7:0] DIVN_out,
  output logic       load,
  input  logic [7:0] R,
  input  logic       Div_complete,
  output logic [7:0] gcd,
  output logic       done,
  output logic       busy,
  output logic       zero_err,
  output logic [3:0] iter
);

  localparam int unsigned WIDTH  = 8;
  localparam int unsigned ITER_W = 4;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_CHECK = 3'd1,
    S_LOAD  = 3'd2,
    S_WAIT  = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t              r_state;
  logic [WIDTH-1:0]    r_x;
  logic [WIDTH-1:0]    r_y;
  logic [WIDTH-1:0]    r_gcd;
  logic [ITER_W-1:0]   r_iter;
  logic                r_zero_err;
  logic                r_load;
  logic                r_done;
  logic                r_busy;
  logic [ITER_W-1:0]   w_iter_inc;
  logic                w_y_zero;

  assign w_y_zero   = (r_y == WIDTH'(0));
  assign w_iter_inc = (r_iter == {ITER_W{1'b1}}) ? r_iter : r_iter + ITER_W'(1);

  // Controller state, operand pair and all registered outputs.
  always_ff @(posedge clk_in or negedge rst_n) begin
    if (!rst_n) begin
      r_state    <= S_IDLE;
      r_x        <= '0;
      r_y        <= '0;
      r_gcd      <= '0;
      r_iter     <= '0;
      r_zero_err <= 1'b0;
      r_load     <= 1'b0;
      r_done     <= 1'b0;
      r_busy     <= 1'b0;
    end else begin
      r_load <= 1'b0;
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_x        <= A;
            r_y        <= B;
            r_iter     <= '0;
            r_zero_err <= 1'b0;
            r_busy     <= 1'b1;
            r_state    <= S_CHECK;
          end
        end
        S_CHECK: begin
          // A zero divisor ends the job; the divider is never loaded with one.
          if (w_y_zero) begin
            r_gcd      <= r_x;
            r_zero_err <= (r_x == WIDTH'(0));
            r_done     <= 1'b1;
            r_state    <= S_DONE;
          end else begin
            r_load  <= 1'b1;
            r_state <= S_LOAD;
          end
        end
        S_LOAD: begin
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (Div_complete) begin
            r_x     <= r_y;
            r_y     <= R;
            r_iter  <= w_iter_inc;
            r_state <= S_CHECK;
          end
        end
        S_DONE: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  assign DIVD_out = r_x;
  assign DIVN_out = r_y;
  assign load     = r_load;
  assign gcd      = r_gcd;
  assign done     = r_done;
  assign busy     = r_busy;
  assign zero_err = r_zero_err;
  assign iter     = r_iter;

endmodule

// File: tb/tb_gcd_ctrl.sv
// Bench for gcd_ctrl: behavioural divider plus an arithmetic Euclid reference.
module tb_gcd_ctrl;

  logic       clk_in = 1'b0;
  logic       rst_n  = 1'b0;
  logic       start  = 1'b0;
  logic [7:0] A = 8'd0;
  logic [7:0] B = 8'd0;
  logic [7:0] R, DIVD_out, DIVN_out, gcd;
  logic       load, Div_complete, done, busy, zero_err;
  logic [3:0] iter;

  int n_tests = 0;
  int n_fail  = 0;

  gcd_ctrl dut (
    .clk_in(clk_in), .rst_n(rst_n), .start(start), .A(A), .B(B),
    .DIVD_out(DIVD_out), .DIVN_out(DIVN_out), .load(load), .R(R),
    .Div_complete(Div_complete), .gcd(gcd), .done(done), .busy(busy),
    .zero_err(zero_err), .iter(iter)
  );

  always #5 clk_in = ~clk_in;

  function automatic int msb_idx(input logic [7:0] v);
    int m = 0;
    for (int i = 0; i < 8; i++) if (v[i]) m = i;
    return m;
  endfunction

  // Divider: count = d+1 on the load negedge, then counts down once per negedge.
  logic [7:0] dv_dd  = 8'd0;
  logic [7:0] dv_dn  = 8'd1;
  int         dv_cnt = 0;
  always @(negedge clk_in) begin
    if (load) begin
      dv_dd  <= DIVD_out;
      dv_dn  <= DIVN_out;
      dv_cnt <= 8 - msb_idx(DIVN_out);
    end else if (dv_cnt > 0) begin
      dv_cnt <= dv_cnt - 1;
    end
  end
  assign Div_complete = (dv_cnt == 0);
  assign R = (dv_dn == 8'd0) ? 8'd0 : (dv_dd % dv_dn);

  // Bus monitor: every load pulse, its operand pair, and done pulses.
  logic [15:0] obs_q[$];
  int  bad_load = 0, long_load = 0, done_cnt = 0;
  bit  prev_load = 1'b0;
  always @(negedge clk_in) begin
    if (load) begin
      obs_q.push_back({DIVD_out, DIVN_out});
      if (DIVN_out == 8'd0) bad_load++;
      if (prev_load) long_load++;
    end
    prev_load = load;
    if (done) done_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic run_job(input logic [7:0] a, input logic [7:0] b, input bit hold);
    logic [7:0]  x, y, t, eg;
    logic [15:0] ep[$];
    int          it, eedge, got_edge, perr;
    bit          got;
    x = a; y = b; it = 0; eedge = 1;
    while (y != 8'd0) begin
      ep.push_back({x, y});
      eedge += 3 + (7 - msb_idx(y));
      t = x % y; x = y; y = t; it++;
    end
    eg = x;
    if (it > 15) it = 15;

    obs_q.delete(); bad_load = 0; long_load = 0; done_cnt = 0;
    @(negedge clk_in); A = a; B = b; start = 1'b1;
    @(posedge clk_in); #1;
    if (!hold) start = 1'b0;
    chk("busy_rise", busy, 1);
    got = 1'b0; got_edge = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk_in); #1;
      if (hold) begin A = 8'($urandom); B = 8'($urandom); end
      if (done) begin got = 1'b1; got_edge = k; break; end
    end
    start = 1'b0;
    chk("done_seen", 32'(got), 1);
    chk("done_edge", got_edge, eedge);
    chk("gcd", gcd, eg);
    chk("iter", iter, it);
    chk("zero_err", zero_err, (a == 8'd0 && b == 8'd0) ? 1 : 0);
    chk("load_count", obs_q.size(), ep.size());
    perr = 0;
    for (int i = 0; i < ep.size() && i < obs_q.size(); i++)
      if (obs_q[i] !== ep[i]) perr++;
    chk("load_operands", perr, 0);
    chk("load_zero_divn", bad_load, 0);
    chk("load_one_cycle", long_load, 0);
    @(posedge clk_in); #1;
    chk("done_one_cycle", done, 0);
    chk("busy_fall", busy, 0);
    chk("done_pulses", done_cnt, 1);
    chk("gcd_hold", gcd, eg);
  endtask

  initial begin
    logic [7:0] ra, rb;
    #12;
    chk("rst_busy", busy, 0);
    chk("rst_load", load, 0);
    chk("rst_done", done, 0);
    chk("rst_gcd", gcd, 0);
    chk("rst_iter", iter, 0);
    chk("rst_zero_err", zero_err, 0);
    chk("rst_divd", DIVD_out, 0);
    chk("rst_divn", DIVN_out, 0);
    @(negedge clk_in); rst_n = 1'b1;

    run_job(8'd17, 8'd0, 1'b0);

    // Abort (48,18) while the divider is running.
    done_cnt = 0;
    @(negedge clk_in); A = 8'd48; B = 8'd18; start = 1'b1;
    @(posedge clk_in); #1; start = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk_in); #1;
      if (load) break;
    end
    @(posedge clk_in); #1;
    @(negedge clk_in); rst_n = 1'b0; #1;
    chk("abort_busy", busy, 0);
    chk("abort_load", load, 0);
    chk("abort_done", done, 0);
    chk("abort_gcd", gcd, 0);
    @(negedge clk_in); rst_n = 1'b1;
    chk("abort_no_done", done_cnt, 0);

    run_job(8'd48, 8'd18, 1'b0);
    run_job(8'd255, 8'd1, 1'b0);
    run_job(8'd0, 8'd0, 1'b0);
    run_job(8'd0, 8'd5, 1'b0);
    run_job(8'd233, 8'd144, 1'b0);
    run_job(8'd48, 8'd18, 1'b1);
    run_job(8'd48, 8'd18, 1'b0);

    for (int n = 0; n < 20; n++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      if (n % 5 == 0) rb = 8'd0;
      run_job(ra, rb, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
